// File: rtl/dcf77_frame_assembler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dcf77_frame_assembler
// Description : Assembles DCF77 second-bits into a 59-bit minute frame,
//               validates markers and parity, publishes BCD time/date.
// Revision    : 1.0  initial release
// ============================================================================
module dcf77_frame_assembler #(
   parameter int GAP_TICKS = 8500,
   parameter int GAP_W     = 16
) (
   input  logic       clk_in,
   input  logic       GSR,
   input  logic       bit_in,
   input  logic       flag_in,
   output logic [6:0] min_out,
   output logic [5:0] hour_out,
   output logic [5:0] day_out,
   output logic [2:0] wday_out,
   output logic [4:0] month_out,
   output logic [7:0] year_out,
   output logic       frame_ok_out,
   output logic       frame_err_out,
   output logic       synced_out
);

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      COLLECT = 2'd1,
      CHECK   = 2'd2
   } state_t;

   localparam logic [GAP_W-1:0] c_gap_max   = GAP_W'(GAP_TICKS);
   localparam logic [GAP_W-1:0] c_gap_pre   = GAP_W'(GAP_TICKS - 1);
   localparam logic [5:0]       c_frame_len = 6'd59;
   localparam logic [5:0]       c_cnt_max   = 6'd60;

   state_t           r_state;
   logic [GAP_W-1:0] r_gap_cnt;
   logic [5:0]       r_bit_cnt;
   logic             r_ovf;
   logic [58:0]      r_frame;

   logic w_marker;
   logic w_valid;
   logic w_unused_bits;

   // The marker fires on the update that makes the counter reach GAP_TICKS;
   // a flag in that same cycle clears the counter instead.
   assign w_marker = !flag_in && (r_gap_cnt == c_gap_pre);

   assign w_valid = (r_bit_cnt == c_frame_len) && !r_ovf
                    && !r_frame[0] && r_frame[20]
                    && !(^r_frame[28:21])
                    && !(^r_frame[35:29])
                    && !(^r_frame[58:36]);

   assign w_unused_bits = ^r_frame[19:1];

   always_ff @(posedge clk_in) begin
      if (GSR) begin
         r_gap_cnt <= '0;
         r_bit_cnt <= '0;
         r_ovf     <= 1'b0;
         r_frame   <= '0;
      end else begin
         if (flag_in)
            r_gap_cnt <= '0;
         else if (r_gap_cnt != c_gap_max)
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);

         if (w_marker) begin
            r_bit_cnt <= '0;
            r_ovf     <= 1'b0;
         end else if (flag_in) begin
            if (r_bit_cnt >= c_frame_len)
               r_ovf <= 1'b1;
            else
               r_frame[r_bit_cnt] <= bit_in;
            if (r_bit_cnt != c_cnt_max)
               r_bit_cnt <= r_bit_cnt + 6'd1;
         end
      end
   end

   // The verdict is registered as CHECK is entered so the ok/err pulse and
   // the new time fields appear in the cycle right after the marker.
   always_ff @(posedge clk_in) begin
      if (GSR) begin
         r_state       <= HUNT;
         min_out       <= '0;
         hour_out      <= '0;
         day_out       <= '0;
         wday_out      <= '0;
         month_out     <= '0;
         year_out      <= '0;
         frame_ok_out  <= 1'b0;
         frame_err_out <= 1'b0;
         synced_out    <= 1'b0;
      end else begin
         frame_ok_out  <= 1'b0;
         frame_err_out <= 1'b0;
         case (r_state)
            HUNT: begin
               if (w_marker) begin
                  synced_out <= 1'b1;
                  r_state    <= COLLECT;
               end
            end
            COLLECT: begin
               if (w_marker) begin
                  if (w_valid) begin
                     min_out      <= r_frame[27:21];
                     hour_out     <= r_frame[34:29];
                     day_out      <= r_frame[41:36];
                     wday_out     <= r_frame[44:42];
                     month_out    <= r_frame[49:45];
                     year_out     <= r_frame[57:50];
                     frame_ok_out <= 1'b1;
                  end else begin
                     frame_err_out <= 1'b1;
                  end
                  r_state <= CHECK;
               end
            end
            CHECK:   r_state <= COLLECT;
            default: r_state <= HUNT;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dcf77_frame_assembler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dcf77_frame_assembler
// Description : Directed bench for the DCF77 frame assembler.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dcf77_frame_assembler;

   localparam int c_gap = 40;
   localparam int c_sp  = 3;

   logic       clk_in  = 1'b0;
   logic       GSR     = 1'b1;
   logic       bit_in  = 1'b0;
   logic       flag_in = 1'b0;
   logic [6:0] min_out;
   logic [5:0] hour_out;
   logic [5:0] day_out;
   logic [2:0] wday_out;
   logic [4:0] month_out;
   logic [7:0] year_out;
   logic       frame_ok_out;
   logic       frame_err_out;
   logic       synced_out;

   int tests_run    = 0;
   int tests_failed = 0;
   int pulses       = 0;

   logic [58:0] fa, fa_bad, fb;

   always #5 clk_in = ~clk_in;

   dcf77_frame_assembler #(.GAP_TICKS(c_gap), .GAP_W(16)) dut (
      .clk_in(clk_in), .GSR(GSR), .bit_in(bit_in), .flag_in(flag_in),
      .min_out(min_out), .hour_out(hour_out), .day_out(day_out),
      .wday_out(wday_out), .month_out(month_out), .year_out(year_out),
      .frame_ok_out(frame_ok_out), .frame_err_out(frame_err_out),
      .synced_out(synced_out)
   );

   function automatic logic [58:0] mk_frame(input logic [6:0] mn, input logic [5:0] hr,
                                            input logic [5:0] dy, input logic [2:0] wd,
                                            input logic [4:0] mo, input logic [7:0] yr,
                                            input logic p1, input logic p2, input logic p3);
      logic [58:0] f;
      f        = '0;
      f[20]    = 1'b1;
      f[27:21] = mn;  f[28] = p1;
      f[34:29] = hr;  f[35] = p2;
      f[41:36] = dy;  f[44:42] = wd;  f[49:45] = mo;  f[57:50] = yr;
      f[58]    = p3;
      return f;
   endfunction

   task automatic tick();
      @(posedge clk_in);
      #1;
      if (frame_ok_out || frame_err_out) pulses++;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send_bit(input logic b);
      idle(c_sp - 1);
      flag_in = 1'b1;
      bit_in  = b;
      tick();
      flag_in = 1'b0;
   endtask

   task automatic send_frame(input logic [58:0] f, input int first, input int count);
      for (int i = first; i < first + count; i++)
         send_bit(i < 59 ? f[i] : 1'b0);
   endtask

   // Silence after the last flag: pulse expected exactly c_gap edges later.
   task automatic finish_minute(input string nm, input logic exp_ok, input logic exp_err,
                                input logic b2b, input logic b2b_bit);
      int p0;
      p0 = pulses;
      idle(c_gap - 1);
      tests_run++;
      if (pulses !== p0) begin
         tests_failed++;
         $display("FAIL %s_early: pulses=%0d expected %0d", nm, pulses, p0);
      end
      tick();
      tests_run++;
      if ({frame_ok_out, frame_err_out} !== {exp_ok, exp_err}) begin
         tests_failed++;
         $display("FAIL %s_pulse: ok,err=%b%b expected %b%b", nm,
                  frame_ok_out, frame_err_out, exp_ok, exp_err);
      end
      if (b2b) begin
         flag_in = 1'b1;
         bit_in  = b2b_bit;
      end
      p0 = pulses;
      tick();
      flag_in = 1'b0;
      tests_run++;
      if (pulses !== p0) begin
         tests_failed++;
         $display("FAIL %s_width: pulses=%0d expected %0d", nm, pulses, p0);
      end
   endtask

   task automatic test_reset(input logic midframe);
      int p0;
      if (midframe) send_frame(fa, 0, 20);
      GSR = 1'b1;
      tick();
      tick();
      tests_run++;
      if ({min_out, hour_out, day_out, wday_out, month_out, year_out,
           frame_ok_out, frame_err_out, synced_out} !== 38'h0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %h expected 0",
                  {min_out, hour_out, day_out, wday_out, month_out, year_out,
                   frame_ok_out, frame_err_out, synced_out});
      end
      GSR = 1'b0;
      p0  = pulses;
      idle(c_gap - 1);
      tests_run++;
      if (synced_out !== 1'b0) begin
         tests_failed++;
         $display("FAIL synced_early: got %b expected 0", synced_out);
      end
      tick();
      tests_run++;
      if (synced_out !== 1'b1) begin
         tests_failed++;
         $display("FAIL synced_set: got %b expected 1", synced_out);
      end
      idle(3);
      tests_run++;
      if (pulses !== p0) begin
         tests_failed++;
         $display("FAIL hunt_no_pulse: pulses=%0d expected %0d", pulses, p0);
      end
      if (midframe) begin
         send_frame(fb, 0, 59);
         finish_minute("post_reset", 1'b1, 1'b0, 1'b0, 1'b0);
         tests_run++;
         if (min_out !== 7'h35) begin
            tests_failed++;
            $display("FAIL post_reset_min: got %h expected 35", min_out);
         end
      end
   endtask

   task automatic test_parity_first();
      send_frame(fa_bad, 0, 59);
      finish_minute("par_first", 1'b0, 1'b1, 1'b0, 1'b0);
      tests_run++;
      if ({min_out, hour_out, day_out, wday_out, month_out, year_out} !== 35'h0) begin
         tests_failed++;
         $display("FAIL par_first_hold: got %h expected 0",
                  {min_out, hour_out, day_out, wday_out, month_out, year_out});
      end
   endtask

   task automatic test_good_frame();
      send_frame(fa, 0, 59);
      finish_minute("good", 1'b1, 1'b0, 1'b0, 1'b0);
      tests_run += 6;
      if (min_out !== 7'h34) begin tests_failed++; $display("FAIL good_min: got %h expected 34", min_out); end
      if (hour_out !== 6'h12) begin tests_failed++; $display("FAIL good_hour: got %h expected 12", hour_out); end
      if (day_out !== 6'h15) begin tests_failed++; $display("FAIL good_day: got %h expected 15", day_out); end
      if (wday_out !== 3'd3) begin tests_failed++; $display("FAIL good_wday: got %h expected 3", wday_out); end
      if (month_out !== 5'h06) begin tests_failed++; $display("FAIL good_month: got %h expected 06", month_out); end
      if (year_out !== 8'h24) begin tests_failed++; $display("FAIL good_year: got %h expected 24", year_out); end
   endtask

   task automatic test_bad_frames();
      logic [34:0] held;
      held = {7'h34, 6'h12, 6'h15, 3'd3, 5'h06, 8'h24};
      for (int k = 0; k < 3; k++) begin
         if (k == 0) send_frame(fa_bad, 0, 59);
         else if (k == 1) send_frame(fa, 0, 58);
         else send_frame(fa, 0, 60);
         finish_minute(k == 0 ? "parity" : (k == 1 ? "short" : "long"),
                       1'b0, 1'b1, 1'b0, 1'b0);
         tests_run++;
         if ({min_out, hour_out, day_out, wday_out, month_out, year_out} !== held) begin
            tests_failed++;
            $display("FAIL bad_hold_%0d: got %h expected %h", k,
                     {min_out, hour_out, day_out, wday_out, month_out, year_out}, held);
         end
      end
   endtask

   task automatic test_gap_boundary();
      int p0;
      p0 = pulses;
      send_bit(1'b0);
      idle(c_gap - 2);
      flag_in = 1'b1; bit_in = 1'b0;
      tick();
      flag_in = 1'b0;
      idle(c_gap - 1);
      flag_in = 1'b1; bit_in = 1'b0;
      tick();
      flag_in = 1'b0;
      tests_run++;
      if (pulses !== p0) begin
         tests_failed++;
         $display("FAIL gap_no_marker: pulses=%0d expected %0d", pulses, p0);
      end
      finish_minute("gap_partial", 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      send_frame(fa, 0, 59);
      finish_minute("b2b_1", 1'b1, 1'b0, 1'b1, fb[0]);
      tests_run++;
      if (min_out !== 7'h34) begin
         tests_failed++;
         $display("FAIL b2b_1_min: got %h expected 34", min_out);
      end
      send_frame(fb, 1, 58);
      finish_minute("b2b_2", 1'b1, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if ({min_out, hour_out, year_out} !== {7'h35, 6'h12, 8'h24}) begin
         tests_failed++;
         $display("FAIL b2b_2_fields: got %h expected %h",
                  {min_out, hour_out, year_out}, {7'h35, 6'h12, 8'h24});
      end
   endtask

   initial begin
      fa     = mk_frame(7'h34, 6'h12, 6'h15, 3'd3, 5'h06, 8'h24, 1'b1, 1'b0, 1'b1);
      fa_bad = mk_frame(7'h34, 6'h12, 6'h15, 3'd3, 5'h06, 8'h24, 1'b0, 1'b0, 1'b1);
      fb     = mk_frame(7'h35, 6'h12, 6'h15, 3'd3, 5'h06, 8'h24, 1'b0, 1'b0, 1'b1);
      test_reset(1'b0);
      test_parity_first();
      test_good_frame();
      test_bad_frames();
      test_gap_boundary();
      test_back_to_back();
      test_reset(1'b1);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
